// File: rtl/codec_pkg.sv
// Shared constants, stereo sample type and receive-word conversion for the CS4272 serial interface.
// Build option: CODEC_RND_EN selects round-half-up with saturation on received samples; default truncates.
package codec_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned CODEC_W     = 24;
  localparam int unsigned SKIP_FRAMES = 2;
  localparam int unsigned FIRST_SLOT  = 1;
  localparam int unsigned LAST_SLOT   = 24;
  localparam int unsigned VALID_CNT   = 905;
  localparam int unsigned SLOT_W      = 5;
  localparam int unsigned SKIP_W      = 2;
  localparam int unsigned PAD_W       = CODEC_W - SAMPLE_W;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] lft;
    logic signed [SAMPLE_W-1:0] rht;
  } stereo_t;

  // Reduce a 24-bit codec word to a 16-bit sample
  function automatic logic [SAMPLE_W-1:0] codec_to_sample(input logic [CODEC_W-1:0] x);
    logic [SAMPLE_W-1:0] hi;
    hi = x[CODEC_W-1 -: SAMPLE_W];
`ifdef CODEC_RND_EN
    // Only the largest positive value can overflow when adding the rounding bit
    if (x[PAD_W-1] && (hi != {1'b0, {(SAMPLE_W-1){1'b1}}}))
      hi = hi + SAMPLE_W'(1);
`endif
    return hi;
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Frame counter and derived codec clocks, SCLK strobes and slot indices.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [CNT_W-1:0]  cnt,
  output logic              mclk,
  output logic              sclk,
  output logic              lrclk,
  output logic              rise_c,
  output logic              fall_c,
  output logic              wrap_c,
  output logic [SLOT_W-1:0] slot_c,
  output logic [SLOT_W-1:0] nslot_c,
  output logic              nhalf_c
);

  logic [SLOT_W:0] nxt_hi;

  // Free-running frame counter, one frame per 1024 clk
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + CNT_W'(1);
  end

  assign mclk   = cnt[1];
  assign sclk   = cnt[3];
  assign lrclk  = cnt[9];
  assign rise_c = (cnt[3:0] == 4'd7);
  assign fall_c = (cnt[3:0] == 4'd15);
  assign wrap_c = (cnt == {CNT_W{1'b1}});
  assign slot_c = cnt[8:4];

  // Slot and half being entered at a fall strobe (low nibble is 15 there, so only the upper bits step)
  assign nxt_hi  = cnt[9:4] + (SLOT_W+1)'(1);
  assign nslot_c = nxt_hi[SLOT_W-1:0];
  assign nhalf_c = nxt_hi[SLOT_W];

endmodule

// File: rtl/codec_intf.sv
// I2S interface to the CS4272: clock/reset generation, 24-bit receive deserializer, 24-bit transmit serializer.
// Build option: CODEC_RND_EN (see codec_pkg) changes only the received-sample conversion.
module codec_intf
  import codec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        RSTn,
  output logic        SDin,
  input  logic        SDout
);

  logic [CNT_W-1:0]   cnt;
  logic               rise_c;
  logic               fall_c;
  logic               wrap_c;
  logic [SLOT_W-1:0]  slot_c;
  logic [SLOT_W-1:0]  nslot_c;
  logic               nhalf_c;

  logic [SKIP_W-1:0]  skip_cnt;
  stereo_t            shadow;
  logic [CODEC_W-1:0] lft_sr;
  logic [CODEC_W-1:0] rht_sr;

  logic               rx_slot_c;
  logic               tx_slot_c;
  logic [CODEC_W-1:0] tx_word_c;
  logic [SLOT_W-1:0]  tx_idx_c;
  logic               load_c;
  logic               skip_done_c;

  codec_clk_gen u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt),
    .mclk    (MCLK),
    .sclk    (SCLK),
    .lrclk   (LRCLK),
    .rise_c  (rise_c),
    .fall_c  (fall_c),
    .wrap_c  (wrap_c),
    .slot_c  (slot_c),
    .nslot_c (nslot_c),
    .nhalf_c (nhalf_c)
  );

  assign rx_slot_c   = (slot_c  >= SLOT_W'(FIRST_SLOT)) && (slot_c  <= SLOT_W'(LAST_SLOT));
  assign tx_slot_c   = (nslot_c >= SLOT_W'(FIRST_SLOT)) && (nslot_c <= SLOT_W'(LAST_SLOT));
  assign tx_word_c   = nhalf_c ? {shadow.rht, {PAD_W{1'b0}}} : {shadow.lft, {PAD_W{1'b0}}};
  assign tx_idx_c    = SLOT_W'(CODEC_W) - nslot_c;
  assign load_c      = (cnt == CNT_W'(VALID_CNT - 1));
  assign skip_done_c = RSTn && (skip_cnt == SKIP_W'(SKIP_FRAMES));

  // Codec reset release at the first frame wrap, then count the startup frames to discard
  always_ff @(posedge clk) begin
    if (rst) begin
      RSTn     <= 1'b0;
      skip_cnt <= '0;
    end else if (wrap_c) begin
      RSTn <= 1'b1;
      if (RSTn && (skip_cnt != SKIP_W'(SKIP_FRAMES)))
        skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end

  // Capture the next frame's samples at the frame boundary and shift them out on SCLK falls
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      SDin   <= 1'b0;
    end else begin
      if (wrap_c)
        shadow <= {lft_out, rht_out};
      if (fall_c)
        SDin <= tx_slot_c ? tx_word_c[tx_idx_c] : 1'b0;
    end
  end

  // Shift SDout into the current half's register on SCLK rises in the data slots
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_sr <= '0;
      rht_sr <= '0;
    end else if (rise_c && rx_slot_c) begin
      if (LRCLK) rht_sr <= {rht_sr[CODEC_W-2:0], SDout};
      else       lft_sr <= {lft_sr[CODEC_W-2:0], SDout};
    end
  end

  // Publish the completed frame once the last right bit is in; flag it only after startup frames
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_in <= '0;
      rht_in <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= load_c && skip_done_c;
      if (load_c) begin
        lft_in <= codec_to_sample(lft_sr);
        rht_in <= codec_to_sample(rht_sr);
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// Directed bench for codec_intf: clocks, codec reset/startup skip, receive, transmit, mid-frame reset.
// Expected values honour CODEC_RND_EN when the bench is built with it.
module tb_codec_intf;

`ifdef CODEC_RND_EN
  localparam logic [15:0] EXP_RHT0 = 16'hFEDD;
  localparam logic [15:0] EXP_NEG  = 16'h0000;
`else
  localparam logic [15:0] EXP_RHT0 = 16'hFEDC;
  localparam logic [15:0] EXP_NEG  = 16'hFFFF;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        RSTn;
  logic        SDin;
  logic        SDout;

  int          checks;
  int          failures;
  int          cyc;
  int          nval;
  logic [23:0] lw;
  logic [23:0] rw;

  codec_intf dut (
    .clk     (clk),
    .rst     (rst),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .RSTn    (RSTn),
    .SDin    (SDin),
    .SDout   (SDout)
  );

  // 50 MHz system clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference cycle count since reset release (cycle 0 is the first cycle after the last reset edge)
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
    end
  end

  // Codec ADC model: I2S, MSB in slot 1, data changes away from the sampling edge
  initial begin
    int tc;
    int k;
    SDout = 1'b0;
    forever begin
      @(negedge clk);
      tc = cyc % 1024;
      k  = (tc / 16) % 32;
      if (k >= 1 && k <= 24) SDout = (tc >= 512) ? rw[24-k] : lw[24-k];
      else                   SDout = 1'b0;
    end
  end

  // Count valid pulses
  initial begin
    nval = 0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) nval = nval + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 20000) begin
      @(negedge clk);
      g = g + 1;
    end
    if (cyc != n) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_cyc: reached=%0d wanted=%0d", cyc, n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lft_in"}, 32'(lft_in), 32'h0);
    chk({tag, "_rht_in"}, 32'(rht_in), 32'h0);
    chk({tag, "_valid"},  32'(valid),  32'h0);
    chk({tag, "_mclk"},   32'(MCLK),   32'h0);
    chk({tag, "_sclk"},   32'(SCLK),   32'h0);
    chk({tag, "_lrclk"},  32'(LRCLK),  32'h0);
    chk({tag, "_rstn"},   32'(RSTn),   32'h0);
    chk({tag, "_sdin"},   32'(SDin),   32'h0);
  endtask

  initial begin
    logic [23:0] txl;
    logic [23:0] txr;
    logic        exp_bit;
    int          nv0;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    lft_out  = 16'h8001;
    rht_out  = 16'h7FFE;
    lw       = 24'h123456;
    rw       = 24'hFEDCBA;

    // Reset state
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Frame 0: clock phases, SDin idle, receive loads without valid, RSTn still low
    wait_cyc(1);    chk("mclk_c1",  32'(MCLK),  32'h0);
    wait_cyc(2);    chk("mclk_c2",  32'(MCLK),  32'h1);
    wait_cyc(4);    chk("mclk_c4",  32'(MCLK),  32'h0);
    wait_cyc(7);    chk("sclk_c7",  32'(SCLK),  32'h0);
    wait_cyc(8);    chk("sclk_c8",  32'(SCLK),  32'h1);
    wait_cyc(15);   chk("sclk_c15", 32'(SCLK),  32'h1);
    wait_cyc(16);   chk("sclk_c16", 32'(SCLK),  32'h0);
                    chk("sdin_f0",  32'(SDin),  32'h0);
    wait_cyc(511);  chk("lrclk_c511", 32'(LRCLK), 32'h0);
    wait_cyc(512);  chk("lrclk_c512", 32'(LRCLK), 32'h1);
    wait_cyc(904);  chk("lft_pre",  32'(lft_in), 32'h0);
    wait_cyc(905);  chk("lft_f0",   32'(lft_in), 32'h1234);
                    chk("rht_f0",   32'(rht_in), 32'(EXP_RHT0));
                    chk("valid_f0", 32'(valid),  32'h0);
    wait_cyc(1023); chk("rstn_c1023",  32'(RSTn),  32'h0);
                    chk("lrclk_c1023", 32'(LRCLK), 32'h1);
                    chk("sclk_c1023",  32'(SCLK),  32'h1);
    wait_cyc(1024); chk("rstn_c1024",  32'(RSTn),  32'h1);
                    chk("lrclk_c1024", 32'(LRCLK), 32'h0);
                    chk("sclk_c1024", 32'(SCLK),  32'h0);

    // Frame 1: transmit 0x8001 / 0x7FFE; lft_out change at cnt 100 must not reach this frame
    txl = {16'h8001, 8'h00};
    txr = {16'h7FFE, 8'h00};
    for (int k = 0; k < 32; k++) begin
      if (k == 7) begin
        wait_cyc(1024 + 100);
        lft_out = 16'h0F0F;
      end
      wait_cyc(1024 + 16 * k);
      exp_bit = (k >= 1 && k <= 24) ? txl[24-k] : 1'b0;
      chk($sformatf("tx_l%0d", k), 32'(SDin), 32'(exp_bit));
    end
    for (int k = 0; k < 32; k++) begin
      wait_cyc(1024 + 512 + 16 * k);
      exp_bit = (k >= 1 && k <= 24) ? txr[24-k] : 1'b0;
      chk($sformatf("tx_r%0d", k), 32'(SDin), 32'(exp_bit));
    end

    // Frame 2: the new left sample goes out
    txl = {16'h0F0F, 8'h00};
    for (int k = 1; k <= 24; k++) begin
      wait_cyc(2048 + 16 * k);
      chk($sformatf("tx2_l%0d", k), 32'(SDin), 32'(txl[24-k]));
    end

    // Startup skip: first valid at 3977, one cycle wide
    wait_cyc(3976); chk("nval_pre",  nval,         0);
    wait_cyc(3977); chk("valid_1st", 32'(valid),   32'h1);
                    chk("lft_1st",   32'(lft_in),  32'h1234);
                    chk("rht_1st",   32'(rht_in),  32'(EXP_RHT0));
    wait_cyc(3978); chk("valid_end", 32'(valid),   32'h0);
                    chk("nval_1st",  nval,         1);

    // Frame 4: rounding of a negative half value and saturation at full scale
    wait_cyc(4096);
    lw = 24'hFFFF80;
    rw = 24'h7FFF80;
    wait_cyc(4096 + 905);
    chk("valid_f4", 32'(valid),  32'h1);
    chk("lft_neg",  32'(lft_in), 32'(EXP_NEG));
    chk("rht_sat",  32'(rht_in), 32'h7FFF);

    // Frame 5: just below the rounding point
    wait_cyc(5120);
    lw = 24'h123456;
    rw = 24'h7FFF7F;
    wait_cyc(5120 + 905);
    chk("valid_f5", 32'(valid),  32'h1);
    chk("lft_f5",   32'(lft_in), 32'h1234);
    chk("rht_7f",   32'(rht_in), 32'h7FFF);

    // Mid-frame reset at cnt 600, held one clk
    wait_cyc(6144 + 600);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    nv0 = nval;
    wait_cyc(1023); chk("rst2_rstn_lo", 32'(RSTn),  32'h0);
    wait_cyc(1024); chk("rst2_rstn_hi", 32'(RSTn),  32'h1);
    wait_cyc(3976); chk("rst2_noval",   nval,       nv0);
    wait_cyc(3977); chk("rst2_valid",   32'(valid), 32'h1);
    wait_cyc(3978); chk("rst2_vend",    32'(valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codec_intf.md
# codec_intf

Serial audio interface between the equalizer datapath and the CS4272 codec. Generates the codec clocks (MCLK, SCLK, LRCLK) and codec reset (RSTn) from the system clock. Deserializes I2S samples from SDout into 16-bit left/right words for the filter bank, and serializes the equalizer's 16-bit left/right results onto SDin.

## Interface
Parameters: none. All constants live in the package.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; **synchronous, active-high**
- lft_out  in  16  signed left sample to codec, from the equalizer
- rht_out  in  16  signed right sample to codec
- lft_in  out  16  signed left sample from codec; reset 0
- rht_in  out  16  signed right sample from codec; reset 0
- valid  out  1  one-cycle pulse when lft_in/rht_in update; reset 0
- MCLK  out  1  codec master clock, clk/4; reset 0
- SCLK  out  1  serial bit clock, clk/16; reset 0
- LRCLK  out  1  frame clock, clk/1024; 0 = left half, 1 = right half; reset 0
- RSTn  out  1  codec reset, active-low; reset 0
- SDin  out  1  serial data to codec DAC; reset 0
- SDout  in  1  serial data from codec ADC

## Operation
- Free-running 10-bit counter cnt, reset 0, +1 per clk, wraps 1023→0.
- MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9]; all driven directly from flops.
- Slot index k = cnt[8:4], range 0..31 within each half. Each half has 32 SCLK periods; each frame has 64.
- SCLK rise strobe: cnt[3:0]==7. SCLK fall strobe: cnt[3:0]==15.
- Receive uses I2S with a one-SCLK delay. On a rise strobe with k in 1..24, shift SDout into a 24-bit shift register, MSB first. The left and right halves use separate registers, selected by cnt[9].
- Transmit:
  - At cnt 1023→0, latch lft_out/rht_out into shadow registers.
  - Transmit word = {shadow, 8'h00}.
  - On a fall strobe entering slot k in 1..24, SDin = bit (24−k) of the current half's word. All other slots drive 0.
- Output update: at the edge after the right-half k=24 capture, load lft_in/rht_in from the 24-bit registers and pulse valid high for exactly the cycle cnt==905.
- Codec reset: RSTn = 0 until cnt first wraps 1023→0 after rst, then 1.
- Startup skip: a 2-bit saturating frame counter starts at RSTn rise. valid is suppressed for the first 2 frames after RSTn = 1, and lft_in/rht_in still load during those frames.
- rst asserted mid-frame: every flop returns to its reset value at the next edge. The counter restarts at 0 and the RSTn/skip sequence repeats.
- Input samples that change mid-frame do not affect the frame in flight.

## Timing
- Frame length 1024 clk = 48.828 kHz.
- Receive latency: last needed bit (right k=24) sampled at cnt 903→904. valid is high during cnt 905.
- Transmit latency: a sample present at cnt==1023 appears MSB-first on SDin from cnt 16 (left) and cnt 528 (right).
- First valid pulse: cycle 3·1024 + 905 after rst deasserts.

## Configuration
- CODEC_RND_EN defined: received sample = saturate(x[23:8] + x[7]).
  - 0x7FFF plus round-up stays 0x7FFF.
  - Negative values round half-up. 0xFFFF80 → 0x0000.
- CODEC_RND_EN not defined: received sample = x[23:8], plain truncation.
- Transmit path is identical in both builds.

## Structure
- Package codec_pkg holds:
  - CNT_W=10, SAMPLE_W=16, CODEC_W=24, SKIP_FRAMES=2, FIRST_SLOT=1, LAST_SLOT=24, VALID_CNT=905
  - typedef stereo_t, a struct with signed [15:0] lft and rht fields.
- One sub-module, codec_clk_gen: the counter, MCLK/SCLK/LRCLK, and the rise/fall strobes and slot index. Serial shift and handshake logic stay in codec_intf.

## Test plan
- Clocks: after rst release, MCLK period 80 ns, SCLK period 320 ns, LRCLK period 20480 ns. LRCLK and SCLK fall on the same clk edge.
- RSTn/skip: RSTn rises 1024 clk after rst release. No valid in the first 2 frames; first valid at clk 3977.
- Receive: codec model sends left 0x123456, right 0xFEDCBA. Then lft_in=0x1234, rht_in=0xFEDC (truncating build), or rht_in=0xFEDD (CODEC_RND_EN build), with a valid pulse one cycle wide.
- Saturation (CODEC_RND_EN build): 0x7FFF80 → 0x7FFF. 0x7FFF7F → 0x7FFF.
- Transmit: lft_out=0x8001, rht_out=0x7FFE. SDin carries left bits 1000_0000_0000_0001 then 8 zeros starting cnt 16, and the right bits likewise from cnt 528. A change to lft_out at cnt 100 is not sent until the next frame.
- Mid-frame rst at cnt 600 held 1 clk: all outputs read 0 next cycle, RSTn re-sequences, and no spurious valid.
